cnn_layer_accel_octo_feeder: RTL and testbench

//   Upstream input sequencer for cnn_layer_accel_octo. On start, pulses new_map, streams
//   num_seq_words_cfg sequence words, then num_pixels_cfg pixel words onto the shared datain bus.

---
 rtl/cnn_layer_accel_octo_feeder.sv | 148 ++++++++++++++
 tb/tb_cnn_layer_accel_octo_feeder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_octo_feeder.sv
// rtl/cnn_layer_accel_octo_feeder.sv - input sequencer feeding seq then pixel words to the octo
module cnn_layer_accel_octo_feeder #(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_DATA_WIDTH     = 16,
  parameter int C_CNT_WIDTH      = 16
) (
  input  logic                    clk_500MHz,
  input  logic                    rst,
  input  logic                    start,
  input  logic [C_CNT_WIDTH-1:0]  num_seq_words_cfg,
  input  logic [C_CNT_WIDTH-1:0]  num_pixels_cfg,
  input  logic [C_DATA_WIDTH-1:0] src_data,
  input  logic                    src_valid,
  output logic                    src_rdy,
  output logic                    new_map,
  output logic                    seq_datain_tag,
  input  logic                    seq_datain_rdy,
  output logic                    pixel_datain_tag,
  input  logic                    pixel_datain_rdy,
  output logic [C_DATA_WIDTH-1:0] datain,
  output logic                    datain_valid,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEWMAP, S_SEQ_GAP, S_SEQ, S_PIX_GAP, S_PIX, S_DONE
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0]  CNT_ONE  = 1;
  // Masks keep only the meaningful low bits of a src word for each phase.
  localparam logic [C_DATA_WIDTH-1:0] SEQ_MASK = {C_DATA_WIDTH{1'b1}} >> (C_DATA_WIDTH - C_SEQ_DATA_WIDTH);
  localparam logic [C_DATA_WIDTH-1:0] PIX_MASK = {C_DATA_WIDTH{1'b1}} >> (C_DATA_WIDTH - C_PIXEL_WIDTH);

  state_t                   state;
  logic [C_CNT_WIDTH-1:0]   seq_cnt_q;
  logic [C_CNT_WIDTH-1:0]   pix_cnt_q;
  logic [C_CNT_WIDTH-1:0]   fetched;
  logic [C_CNT_WIDTH-1:0]   sent;
  logic                     in_phase;
  logic [C_CNT_WIDTH-1:0]   cur_cnt;
  logic                     dst_rdy;
  logic                     xfer;
  logic                     last_xfer;
  logic                     src_take;
  logic [C_DATA_WIDTH-1:0]  src_masked;

  // Phase decode from the registered tags; the inactive phase's rdy never reaches dst_rdy.
  always_comb begin
    in_phase   = seq_datain_tag | pixel_datain_tag;
    cur_cnt    = seq_datain_tag ? seq_cnt_q : pix_cnt_q;
    dst_rdy    = (seq_datain_tag & seq_datain_rdy) | (pixel_datain_tag & pixel_datain_rdy);
    xfer       = datain_valid & dst_rdy;
    last_xfer  = xfer & ((sent + CNT_ONE) == cur_cnt);
    src_rdy    = in_phase & (fetched < cur_cnt) & (~datain_valid | dst_rdy);
    src_take   = src_valid & src_rdy;
    src_masked = src_data & (seq_datain_tag ? SEQ_MASK : PIX_MASK);
  end

  // Load sequencing FSM with registered phase outputs and per-phase word counters.
  always_ff @(posedge clk_500MHz or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      seq_cnt_q        <= '0;
      pix_cnt_q        <= '0;
      fetched          <= '0;
      sent             <= '0;
      new_map          <= 1'b0;
      seq_datain_tag   <= 1'b0;
      pixel_datain_tag <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      if (src_take) fetched <= fetched + CNT_ONE;
      if (xfer)     sent    <= sent + CNT_ONE;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            seq_cnt_q <= num_seq_words_cfg;
            pix_cnt_q <= num_pixels_cfg;
            new_map   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_NEWMAP;
          end
        end
        S_NEWMAP: begin
          new_map <= 1'b0;
          state   <= S_SEQ_GAP;
        end
        S_SEQ_GAP: begin
          fetched <= '0;
          sent    <= '0;
          if (seq_cnt_q != '0) begin
            seq_datain_tag <= 1'b1;
            state          <= S_SEQ;
          end else begin
            state <= S_PIX_GAP;
          end
        end
        S_SEQ: begin
          if (last_xfer) begin
            seq_datain_tag <= 1'b0;
            state          <= S_PIX_GAP;
          end
        end
        S_PIX_GAP: begin
          fetched <= '0;
          sent    <= '0;
          if (pix_cnt_q != '0) begin
            pixel_datain_tag <= 1'b1;
            state            <= S_PIX;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_PIX: begin
          if (last_xfer) begin
            pixel_datain_tag <= 1'b0;
            done             <= 1'b1;
            state            <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry output register: refills on a src take, empties on an octo transfer.
  always_ff @(posedge clk_500MHz or posedge rst) begin
    if (rst) begin
      datain       <= '0;
      datain_valid <= 1'b0;
    end else if (src_take) begin
      datain       <= src_masked;
      datain_valid <= 1'b1;
    end else if (xfer) begin
      datain_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_octo_feeder.sv
// tb/tb_cnn_layer_accel_octo_feeder.sv - scoreboard bench for cnn_layer_accel_octo_feeder
`timescale 1ns/1ps
module tb_cnn_layer_accel_octo_feeder;

  logic        clk_500MHz = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_seq_words_cfg = '0;
  logic [15:0] num_pixels_cfg = '0;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_rdy;
  logic        new_map;
  logic        seq_datain_tag;
  logic        seq_datain_rdy = 1'b0;
  logic        pixel_datain_tag;
  logic        pixel_datain_rdy = 1'b0;
  logic [15:0] datain;
  logic        datain_valid;
  logic        busy;
  logic        done;

  cnn_layer_accel_octo_feeder dut (
    .clk_500MHz(clk_500MHz), .rst(rst), .start(start),
    .num_seq_words_cfg(num_seq_words_cfg), .num_pixels_cfg(num_pixels_cfg),
    .src_data(src_data), .src_valid(src_valid), .src_rdy(src_rdy),
    .new_map(new_map), .seq_datain_tag(seq_datain_tag), .seq_datain_rdy(seq_datain_rdy),
    .pixel_datain_tag(pixel_datain_tag), .pixel_datain_rdy(pixel_datain_rdy),
    .datain(datain), .datain_valid(datain_valid), .busy(busy), .done(done)
  );

  always #5 clk_500MHz = ~clk_500MHz;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_data[$];
  bit          sb_seq[$];
  int          g_first_seq, g_last_seq, g_first_pix, g_last_pix, g_done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one load; abort_after>0 asserts rst after that many pixel transfers.
  task automatic run_load(input int seq_n, input int pix_n, input int valid_pct,
                          input int rdy_mode, input int abort_after, input bit start_mid);
    int seq_x = 0, pix_x = 0, nm = 0, dn = 0, seq_i = 0, pix_i = 0;
    bit hold = 0, both = 0, seen_done = 0, seq_tag_seen = 0, xfer, pop_seq;
    logic [15:0] held = '0, exp_d;
    g_first_seq = -1; g_last_seq = -1; g_first_pix = -1; g_last_pix = -1; g_done_cyc = -1;
    @(negedge clk_500MHz);
    start = 1'b1;
    num_seq_words_cfg = 16'(seq_n);
    num_pixels_cfg = 16'(pix_n);
    @(negedge clk_500MHz);
    start = 1'b0;
    num_seq_words_cfg = 16'($urandom);
    num_pixels_cfg = 16'($urandom);
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (new_map) nm++;
      if (done) begin dn++; g_done_cyc = cyc; seen_done = 1; end
      if (seq_datain_tag && pixel_datain_tag) both = 1;
      if (seq_datain_tag) seq_tag_seen = 1;
      check("occupancy", {31'd0, datain_valid}, {31'd0, sb_data.size() != 0});
      if (hold) check("hold_stable", {16'd0, datain}, {16'd0, held});
      src_valid = ($urandom_range(99) < valid_pct);
      if (seq_datain_tag)        src_data = (seq_i == 0) ? 16'hFFFF : 16'($urandom);
      else if (pixel_datain_tag) src_data = (pix_i == 0) ? 16'hABCD : 16'($urandom);
      else                       src_data = 16'($urandom);
      case (rdy_mode)
        0: begin seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b1; end
        1: begin seq_datain_rdy = cyc[0]; pixel_datain_rdy = ~seq_datain_rdy; end
        default: begin seq_datain_rdy = $urandom_range(1); pixel_datain_rdy = $urandom_range(1); end
      endcase
      start = start_mid && (cyc == 20);
      #1;
      xfer = datain_valid && ((seq_datain_tag && seq_datain_rdy) || (pixel_datain_tag && pixel_datain_rdy));
      if (src_valid && src_rdy) begin
        sb_data.push_back(seq_datain_tag ? (src_data & 16'h1FFF) : src_data);
        sb_seq.push_back(seq_datain_tag);
        if (seq_datain_tag) seq_i++; else pix_i++;
      end
      if (xfer) begin
        if (sb_data.size() == 0) begin
          check("xfer_without_word", 32'd1, 32'd0);
        end else begin
          exp_d = sb_data.pop_front();
          pop_seq = sb_seq.pop_front();
          check("datain", {16'd0, datain}, {16'd0, exp_d});
          check("phase", {31'd0, seq_datain_tag}, {31'd0, pop_seq});
        end
        if (seq_datain_tag) begin
          if (g_first_seq < 0) g_first_seq = cyc;
          g_last_seq = cyc; seq_x++;
        end else begin
          if (g_first_pix < 0) g_first_pix = cyc;
          g_last_pix = cyc; pix_x++;
        end
      end
      hold = datain_valid && (seq_datain_tag || pixel_datain_tag) && !xfer;
      held = datain;
      if (abort_after > 0 && pix_x == abort_after) begin
        @(posedge clk_500MHz);
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", {23'd0, datain, datain_valid, seq_datain_tag, pixel_datain_tag,
                              busy, new_map, done, src_rdy}, 32'd0);
        @(negedge clk_500MHz);
        check("rst_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        src_valid = 1'b0;
        sb_data.delete();
        sb_seq.delete();
        return;
      end
      @(negedge clk_500MHz);
    end
    src_valid = 1'b0;
    check("done_seen", {31'd0, seen_done}, 32'd1);
    check("seq_count", seq_x, seq_n);
    check("pix_count", pix_x, pix_n);
    check("seq_fetched", seq_i, seq_n);
    check("pix_fetched", pix_i, pix_n);
    check("new_map_pulses", nm, 1);
    check("done_pulses", dn, 1);
    check("both_tags", {31'd0, both}, 32'd0);
    check("seq_tag_seen", {31'd0, seq_tag_seen}, {31'd0, seq_n != 0});
    check("sb_empty", sb_data.size(), 0);
    @(negedge clk_500MHz);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_outputs", {23'd0, datain, datain_valid, seq_datain_tag, pixel_datain_tag,
                            busy, new_map, done, src_rdy}, 32'd0);
    @(negedge clk_500MHz);
    rst = 1'b0;

    // Test 1: full-rate load with timing, plus an ignored start mid-load
    run_load(40, 100, 100, 0, 0, 1'b1);
    check("t1_first_seq", g_first_seq, 3);
    check("t1_seq_b2b", g_last_seq - g_first_seq, 39);
    check("t1_seq_to_pix", g_first_pix - g_last_seq, 3);
    check("t1_pix_b2b", g_last_pix - g_first_pix, 99);
    check("t1_done_lat", g_done_cyc - g_last_pix, 1);

    // Test 2: toggling rdy
    run_load(40, 100, 100, 1, 0, 1'b0);
    // Test 3: starved source, then random back-pressure too
    run_load(40, 100, 50, 0, 0, 1'b0);
    run_load(25, 60, 70, 2, 0, 1'b0);
    // Test 4: empty phases
    run_load(0, 4, 100, 0, 0, 1'b0);
    run_load(0, 0, 100, 0, 0, 1'b0);
    check("t4_empty_done_cyc", g_done_cyc, 3);
    // Test 6: abort then clean load
    run_load(40, 100, 100, 0, 10, 1'b0);
    run_load(40, 100, 100, 0, 0, 1'b0);
    check("t6_seq_b2b", g_last_seq - g_first_seq, 39);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
